receive_comm: RTL

//   Serial receiver stage directly downstream of the transmit shifter; consumes its serial_out line.

---
 rtl/receive_comm_if.sv | 47 ++++
 rtl/receive_comm.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/receive_comm_if.sv
// -----------------------------------------------------------------------------
// receive_comm_if
//   Signal bundle between the serial receiver and its surroundings.
//   master : line driver / consumer side (drives sample_en, serial_in, rd_ack)
//   slave  : receiver side (drives the recovered character and status)
//
//   sample_en      sample tick; receiver state advances only when high
//   serial_in      line from the transmitter serial_out, idle 1
//   rd_ack         consumer has taken parallel_out
//   parallel_out   last completed character
//   char_received  one-clk pulse when a frame completes
//   data_valid     high from frame completion until rd_ack
//   frame_err      1 = stop bit of the last frame sampled 0
//   overrun        sticky: a frame completed while data_valid was still set
// -----------------------------------------------------------------------------
interface receive_comm_if;
    logic       sample_en;
    logic       serial_in;
    logic       rd_ack;
    logic [7:0] parallel_out;
    logic       char_received;
    logic       data_valid;
    logic       frame_err;
    logic       overrun;

    modport master (
        output sample_en,
        output serial_in,
        output rd_ack,
        input  parallel_out,
        input  char_received,
        input  data_valid,
        input  frame_err,
        input  overrun
    );

    modport slave (
        input  sample_en,
        input  serial_in,
        input  rd_ack,
        output parallel_out,
        output char_received,
        output data_valid,
        output frame_err,
        output overrun
    );
endinterface

// File: rtl/receive_comm.sv
// -----------------------------------------------------------------------------
// receive_comm
//   Serial receiver for the transmit shifter line. Frame: idle-high, start bit 0,
//   8 data bits MSB first, stop bit 1. Each bit lasts SAMPLES_PER_BIT sample
//   ticks and is sampled at tick MID of the bit.
//
//   clk    in  system clock, all state on posedge
//   reset  in  asynchronous, active-high reset
//   bus    slave side of receive_comm_if (line, tick, handshake and status)
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   IDLE       | line idle, waiting for a low sample (start of start bit)
//   START      | inside start bit, confirming it at the mid sample
//   DATA       | shifting in 8 data bits, one per bit period
//   STOP       | waiting for the stop bit mid sample to complete the frame
//   WAIT_HIGH  | stop bit was low (break/error); hold until the line is high
// -----------------------------------------------------------------------------
module receive_comm #(
    parameter int SAMPLES_PER_BIT = 1
) (
    input  logic           clk,
    input  logic           reset,
    receive_comm_if.slave  bus
);

    localparam int MID = (SAMPLES_PER_BIT - 1) / 2;
    localparam int SW  = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;

    localparam logic [SW-1:0] S_MID  = SW'(MID);
    localparam logic [SW-1:0] S_LAST = SW'(SAMPLES_PER_BIT - 1);
    localparam logic [SW-1:0] S_ONE  = SW'(1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [SW-1:0] s_q, s_d;
    logic [2:0]    b_q, b_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    pout_q, pout_d;
    logic          crx_q, crx_d;
    logic          dv_q, dv_d;
    logic          fe_q, fe_d;
    logic          ovr_q, ovr_d;
    logic          done;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        b_d     = b_q;
        shreg_d = shreg_q;
        pout_d  = pout_q;
        crx_d   = 1'b0;
        dv_d    = dv_q;
        fe_d    = fe_q;
        ovr_d   = ovr_q;
        done    = 1'b0;

        if (bus.sample_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (!bus.serial_in) begin
                        // This tick is sample 0 of the start bit. With MID==0
                        // the start is already confirmed here.
                        if (MID == 0) begin
                            state_d = ST_DATA;
                            s_d     = '0;
                            b_d     = 3'd0;
                        end else begin
                            state_d = ST_START;
                            s_d     = S_ONE;
                        end
                    end
                end

                ST_START: begin
                    if (s_q == S_MID && bus.serial_in) begin
                        state_d = ST_IDLE;
                        s_d     = '0;
                    end else if (s_q == S_LAST) begin
                        state_d = ST_DATA;
                        s_d     = '0;
                        b_d     = 3'd0;
                    end else begin
                        s_d = s_q + S_ONE;
                    end
                end

                ST_DATA: begin
                    if (s_q == S_MID)
                        shreg_d = {shreg_q[6:0], bus.serial_in};
                    if (s_q == S_LAST) begin
                        s_d = '0;
                        if (b_q == 3'd7)
                            state_d = ST_STOP;
                        else
                            b_d = b_q + 3'd1;
                    end else begin
                        s_d = s_q + S_ONE;
                    end
                end

                ST_STOP: begin
                    if (s_q == S_MID) begin
                        done    = 1'b1;
                        pout_d  = shreg_q;
                        crx_d   = 1'b1;
                        fe_d    = ~bus.serial_in;
                        s_d     = '0;
                        // A low stop bit means break or misframing: resync on
                        // the next high level instead of treating it as a start.
                        state_d = bus.serial_in ? ST_IDLE : ST_WAIT_HIGH;
                    end else begin
                        s_d = s_q + S_ONE;
                    end
                end

                ST_WAIT_HIGH: begin
                    if (bus.serial_in)
                        state_d = ST_IDLE;
                end

                default: begin
                    state_d = ST_IDLE;
                    s_d     = '0;
                    b_d     = 3'd0;
                end
            endcase
        end

        // Completion wins over a simultaneous rd_ack: the new character is
        // still unread, and overrun only flags a character that was lost.
        if (done) begin
            if (dv_q && !bus.rd_ack)
                ovr_d = 1'b1;
            dv_d = 1'b1;
        end else if (bus.rd_ack && dv_q) begin
            dv_d  = 1'b0;
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            b_q     <= 3'd0;
            shreg_q <= 8'h00;
            pout_q  <= 8'h00;
            crx_q   <= 1'b0;
            dv_q    <= 1'b0;
            fe_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            b_q     <= b_d;
            shreg_q <= shreg_d;
            pout_q  <= pout_d;
            crx_q   <= crx_d;
            dv_q    <= dv_d;
            fe_q    <= fe_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.parallel_out  = pout_q;
    assign bus.char_received = crx_q;
    assign bus.data_valid    = dv_q;
    assign bus.frame_err     = fe_q;
    assign bus.overrun       = ovr_q;

endmodule
